// File: rtl/c499_pattern_sequencer.sv
// c499_pattern_sequencer: streams test patterns into a golden and a suspect
// c499 that share one input bus. After each pattern has settled, it compares
// the two responses and keeps the failure statistics for the run.
// Build option: define C499SEQ_STOP_ON_FAIL_EN to end a run at its first
// failing pattern.
module c499_pattern_sequencer #(
    parameter int PAT_W         = 41,
    parameter int OUT_W         = 32,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             pat_valid,
    input  logic [PAT_W-1:0] pat_data,
    output logic             pat_ready,
    output logic [PAT_W-1:0] dut_in,
    input  logic [OUT_W-1:0] gold_out,
    input  logic [OUT_W-1:0] sus_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [OUT_W-1:0] last_diff
);

    // The settle counter needs at least one bit, even when SETTLE_CYCLES is 0.
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] num_q;
    logic [SW-1:0]    settle_cnt;
    logic [OUT_W-1:0] diff;
    logic             last_pat;

    assign diff     = gold_out ^ sus_out;
    assign last_pat = (idx == num_q - CNT_W'(1));

    // Next-state decode. abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)
                    state_nxt = (num_patterns == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (pat_valid)
                    state_nxt = (SETTLE_CYCLES == 0) ? S_COMPARE : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt <= SW'(1))
                    state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
`ifdef C499SEQ_STOP_ON_FAIL_EN
                if (diff != '0 || last_pat)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_FETCH;
`else
                state_nxt = last_pat ? S_DONE : S_FETCH;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort)
            state_nxt = S_IDLE;
    end

    // FSM state and the handshake/status flags, all registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pat_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pat_ready <= (state_nxt == S_FETCH);
            busy      <= (state_nxt == S_FETCH) || (state_nxt == S_SETTLE) ||
                         (state_nxt == S_COMPARE);
            done      <= (state_nxt == S_DONE);
        end
    end

    // Datapath: pattern capture, settle timing, index and failure statistics.
    // Nothing updates in a cycle with abort, so a handshake in that cycle is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in           <= '0;
            settle_cnt       <= '0;
            idx              <= '0;
            num_q            <= '0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            last_diff        <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_q            <= num_patterns;
                        idx              <= '0;
                        mismatch_count   <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
                        last_diff        <= '0;
                    end
                end
                S_FETCH: begin
                    if (pat_valid) begin
                        dut_in     <= pat_data;
                        settle_cnt <= SW'(SETTLE_CYCLES);
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - SW'(1);
                end
                S_COMPARE: begin
                    if (diff != '0) begin
                        if (mismatch_count != '1)
                            mismatch_count <= mismatch_count + CNT_W'(1);
                        last_diff <= diff;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_idx   <= idx;
                        end
                    end
                    if (state_nxt == S_FETCH)
                        idx <= idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/c499_pattern_sequencer.md
Name: c499_pattern_sequencer

Overview:
- Applies a stream of 41-bit test patterns to two c499 instances that share one input bus: a golden copy and a suspect (possibly trojan-infected) copy.
- Waits a programmable settle time after each pattern, then compares the two 32-bit responses.
- Reports the mismatch count, the index of the first failing pattern, and the diff vector of the most recent failure.
- Sits between the evolutionary pattern generator (upstream valid/ready stream) and the golden/suspect c499 netlists.

Parameters:
- PAT_W, 41, pattern width (c499 inputs)
- OUT_W, 32, response width (c499 outputs)
- CNT_W, 16, width of pattern counters and indices
- SETTLE_CYCLES, 2, cycles between dut_in update and compare; 0 is legal

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- abort  in  1  synchronous abort; returns to IDLE from any state
- num_patterns  in  CNT_W  patterns in the run; latched on start
- pat_valid  in  1  upstream pattern valid
- pat_data  in  PAT_W  upstream pattern
- pat_ready  out  1  high only in FETCH
- dut_in  out  PAT_W  registered pattern driven to both c499 instances
- gold_out  in  OUT_W  golden c499 response
- sus_out  in  OUT_W  suspect c499 response
- busy  out  1  high in FETCH, SETTLE and COMPARE
- done  out  1  high while in DONE
- mismatch_count  out  CNT_W  count of failing patterns; saturates at all-ones
- first_fail_valid  out  1  at least one mismatch this run
- first_fail_idx  out  CNT_W  0-based index of the first failing pattern
- last_diff  out  OUT_W  gold_out^sus_out of the most recent failing pattern

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0; dut_in=0.
  - Internal pattern index and settle counter are 0.
- States: IDLE, FETCH, SETTLE, COMPARE, DONE. Encoding is free.
- IDLE/DONE with start=1:
  - Latch num_patterns.
  - Clear mismatch_count, first_fail_valid, first_fail_idx, last_diff and the index.
  - If the latched num_patterns==0, go to DONE; otherwise go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - pat_ready=1.
  - On pat_valid&pat_ready: dut_in<=pat_data, settle counter<=SETTLE_CYCLES.
  - Next state is SETTLE, or COMPARE if SETTLE_CYCLES==0.
  - Without pat_valid, stay in FETCH indefinitely.
- SETTLE:
  - Decrement the counter each cycle.
  - Go to COMPARE in the cycle the counter reaches 1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  - dut_in is held stable.
- COMPARE (exactly one cycle):
  - diff=gold_out^sus_out, sampled in this cycle.
  - If diff!=0:
    - mismatch_count+1, saturating.
    - last_diff<=diff.
    - If first_fail_valid==0: first_fail_valid<=1, first_fail_idx<=index.
  - If index==num_patterns-1, go to DONE; otherwise index+1 and go to FETCH.
- Throughput: with pat_valid held high, each pattern takes SETTLE_CYCLES+2 cycles.
- DONE: done=1, busy=0. Result outputs hold until the next start or reset.
- abort (wins over all other events in the same cycle):
  - Go to IDLE.
  - Results and dut_in hold their current values; done=0.
  - A pattern handshake in the same cycle is dropped: dut_in is not updated and the pattern is not counted.
- num_patterns=all-ones runs 65535 patterns; the index never wraps inside a run.
- Reset mid-run: immediate return to IDLE with all outputs zero.

Optional Feature:
- Macro: C499SEQ_STOP_ON_FAIL_EN.
- Defined:
  - The first COMPARE with diff!=0 goes straight to DONE after updating the results, whatever the remaining count.
  - mismatch_count is therefore at most 1.
- Undefined: the run always processes all num_patterns patterns.

Test Plan:
- Reset mid-SETTLE (rst_n low for 1 cycle) -> all outputs 0, state IDLE; a following start runs normally.
- num_patterns=4, SETTLE_CYCLES=2, pat_valid held high, gold_out==sus_out -> done asserts 16 cycles after start; mismatch_count=0, first_fail_valid=0.
- num_patterns=5, sus_out differs (0x00000100) only while dut_in equals pattern index 2 and index 4 -> mismatch_count=2, first_fail_idx=2, last_diff=0x00000100.
- Same stimulus with C499SEQ_STOP_ON_FAIL_EN -> done right after pattern 2's COMPARE; mismatch_count=1; pattern 3 is never handshaked.
- pat_valid toggling with 3-cycle gaps, num_patterns=3 -> dut_in changes only on handshakes and is stable throughout SETTLE; exactly 3 handshakes occur.
- num_patterns=0 -> DONE one cycle after start with no handshake. Separately, abort during FETCH with pat_valid=1 -> IDLE, no handshake counted, done=0.
